// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory slave that stalls the pipeline while an access is in flight.
// Defining DMEM_BYTE_EN adds the req_be byte-lane write enables.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic lat_we, a_we, idle, commit, a_err;
    logic [31:0] lat_addr, lat_wdata, a_addr, a_wdata, wmask;
    logic [3:0] lat_be, a_be, be_in;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];
`ifdef DMEM_BYTE_EN
    assign be_in = req_be;
`else
    assign be_in = 4'hF;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        idle      = state == IDLE;
        state_nx  = idle ? (req_valid ? ((LATENCY == 1) ? RESP : WAIT) : IDLE)
                  : (state == WAIT) ? ((cnt == 4'd1) ? RESP : WAIT) : IDLE;
        req_ready = idle;
        rsp_valid = state == RESP;
        stall     = (idle && req_valid) || state == WAIT;
        // With LATENCY 1 the access commits on the acceptance edge, so take the live request fields
        a_we      = idle ? req_we : lat_we;
        a_addr    = idle ? req_addr : lat_addr;
        a_wdata   = idle ? req_wdata : lat_wdata;
        a_be      = idle ? be_in : lat_be;
        commit    = rst_n && state_nx == RESP && state != RESP;
        a_err     = (a_addr[1:0] != 2'b00) || ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
        idx       = a_addr[AW+1:2];
        wmask     = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (idle && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= be_in;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= a_err;
                rsp_rdata <= (a_we || a_err) ? '0 : mem[idx];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (commit && a_we && !a_err) mem[idx] <= (mem[idx] & ~wmask) | (a_wdata & wmask);
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: LATENCY 1 and LATENCY 2 responders share one request stream and are checked against a transaction model.
module tb_dmem_responder;
`ifdef DMEM_BYTE_EN
    localparam bit HAS_BE = 1'b1;
`else
    localparam bit HAS_BE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0] be_cur = 4'hF;
`ifdef DMEM_BYTE_EN
    logic [3:0] req_be;
    assign req_be = be_cur;
`endif
    logic rdy [2];
    logic rv [2];
    logic er [2];
    logic stl [2];
    logic [31:0] rd [2];
    int checks = 0;
    int fails = 0;
    int rem [2];
    int pulses [2];
    logic p_we [2];
    logic exp_err [2];
    logic last_err [2];
    logic [3:0] p_be [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd [2];
    logic [31:0] mm [2][64];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
        .req_be(req_be),
`endif
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]), .stall(stl[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
        .req_be(req_be),
`endif
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]), .stall(stl[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic access(input int i);
        logic bad;
        int idx;
        bad = (p_addr[i][1:0] != 2'b00) || (p_addr[i][31:2] >= 30'd64);
        idx = int'(p_addr[i][7:2]);
        exp_err[i] = bad;
        exp_rd[i] = '0;
        if (!bad && p_we[i]) begin
            for (int b = 0; b < 4; b++)
                if (p_be[i][b]) mm[i][idx][8*b +: 8] = p_wdata[i][8*b +: 8];
        end else if (!bad) begin
            exp_rd[i] = mm[i][idx];
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rem[i] > 0) begin
                rem[i]--;
            end else if (req_valid) begin
                rem[i] = i + 1;
                p_we[i] = req_we;
                p_addr[i] = req_addr;
                p_wdata[i] = req_wdata;
                p_be[i] = HAS_BE ? be_cur : 4'hF;
            end
            if (rem[i] == 1) access(i);
        end
    endtask

    task automatic tick(input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        req_valid = v;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        be_cur = be;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rsp_valid%0d", i), 32'(rv[i]), 32'(rem[i] == 1));
            chk($sformatf("req_ready%0d", i), 32'(rdy[i]), 32'(rem[i] == 0));
            chk($sformatf("stall%0d", i), 32'(stl[i]), 32'((rem[i] == 0 && v) || rem[i] > 1));
            if (rem[i] == 1) begin
                chk($sformatf("rdata%0d", i), rd[i], exp_rd[i]);
                chk($sformatf("err%0d", i), 32'(er[i]), 32'(exp_err[i]));
            end
            if (rv[i]) begin
                last_rd[i] = rd[i];
                last_err[i] = er[i];
                pulses[i]++;
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        tick(1'b1, we, addr, wdata, be);
        repeat (3) tick(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_rsp_valid%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("rst_req_ready%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_stall%0d", i), 32'(stl[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), rd[i], 32'd0);
            chk($sformatf("rst_err%0d", i), 32'(er[i]), 32'd0);
            rem[i] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rem[0] = 0;
        rem[1] = 0;
        pulses[0] = 0;
        pulses[1] = 0;
        #2;
        pulse_reset();
        for (int k = 0; k < 64; k++) xact(1'b1, 32'(k * 4), 32'h0, 4'hF);

        xact(1'b1, 32'h8, 32'h20000022, 4'hF);
        chk("wr8_err", 32'(last_err[1]), 32'd0);
        xact(1'b0, 32'h8, 32'h0, 4'hF);
        chk("rd8_lat2", last_rd[1], 32'h20000022);
        chk("rd8_lat1", last_rd[0], 32'h20000022);

        pulses[0] = 0;
        for (int c = 0; c < 6; c++) tick(1'b1, 1'b0, (c >= 2) ? 32'h4 : 32'h0, 32'h0, 4'hF);
        chk("b2b_pulses_lat1", 32'(pulses[0]), 32'd3);
        repeat (3) tick(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);

        xact(1'b0, 32'h6, 32'h0, 4'hF);
        chk("misalign_err", 32'(last_err[1]), 32'd1);
        chk("misalign_rdata", last_rd[1], 32'd0);
        xact(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        chk("range_err", 32'(last_err[1]), 32'd1);
        chk("range_err_lat1", 32'(last_err[0]), 32'd1);
        for (int k = 0; k < 64; k++) xact(1'b0, 32'(k * 4), 32'h0, 4'hF);

        tick(1'b1, 1'b1, 32'h10, 32'h40000044, 4'hF);
        pulse_reset();
        xact(1'b0, 32'h10, 32'h0, 4'hF);
        chk("rst_drop_write", last_rd[1], 32'h0);
        chk("rst_lat1_committed", last_rd[0], 32'h40000044);

        tick(1'b1, 1'b1, 32'h10, 32'h40000044, 4'hF);
        tick(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF);
        repeat (2) tick(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF);
        xact(1'b0, 32'h10, 32'h0, 4'hF);
        chk("latched_wr", last_rd[1], 32'h40000044);
        xact(1'b0, 32'h14, 32'h0, 4'hF);
        chk("untouched_14", last_rd[1], 32'h0);

        if (HAS_BE) begin
            xact(1'b1, 32'h0, 32'hA00000AA, 4'hF);
            xact(1'b1, 32'h0, 32'h11223344, 4'b0101);
            xact(1'b1, 32'h0, 32'h55555555, 4'h0);
            chk("be0_err", 32'(last_err[1]), 32'd0);
            xact(1'b0, 32'h0, 32'h0, 4'h0);
            chk("be_merge", last_rd[1], 32'hA0220044);
        end

        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 7));
            a = (sel < 6) ? {24'h0, 6'($urandom), 2'b00}
              : (sel == 6) ? {24'h0, 6'($urandom), 2'($urandom_range(1, 3))}
              : ($urandom | 32'h100);
            tick(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        end
        repeat (4) tick(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
